instr_encoder: RTL and testbench

Streaming MIPS instruction encoder, the inverse of the control decoder. Takes structured requests (operation select plus register, immediate and index fields) and emits 32-bit machine words for the supported subset: nop, add, sub, ori, lw, sw, beq, lui, jal, jr. Words are buffered in a small FIFO and presented with a word address. The block feeds instruction-memory preload and self-checking program generation on the P5 test fabric.

---
 rtl/instr_encoder.sv | 127 ++++++++++++
 tb/tb_instr_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Brief    : Streaming MIPS instruction encoder with output FIFO and word address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic [4:0]                 in_rs,
    input  logic [4:0]                 in_rt,
    input  logic [4:0]                 in_rd,
    input  logic [15:0]                in_imm,
    input  logic [25:0]                in_index,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_word,
    output logic [31:0]                out_addr,
    output logic                       err,
    output logic [7:0]                 err_count,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full  = DEPTH[c_ptr_w:0];

    localparam logic [3:0] c_op_nop = 4'd0;
    localparam logic [3:0] c_op_add = 4'd1;
    localparam logic [3:0] c_op_sub = 4'd2;
    localparam logic [3:0] c_op_ori = 4'd3;
    localparam logic [3:0] c_op_lw  = 4'd4;
    localparam logic [3:0] c_op_sw  = 4'd5;
    localparam logic [3:0] c_op_beq = 4'd6;
    localparam logic [3:0] c_op_lui = 4'd7;
    localparam logic [3:0] c_op_jal = 4'd8;
    localparam logic [3:0] c_op_jr  = 4'd9;

    logic [31:0]        r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_level;
    logic [31:0]        r_addr;
    logic               r_err;
    logic [7:0]         r_err_count;

    logic [31:0]        w_word;
    logic               w_legal;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;

    always_comb begin
        w_word  = 32'h0;
        w_legal = 1'b1;
        case (in_op)
            c_op_nop: w_word = 32'h0;
            c_op_add: w_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h20};
            c_op_sub: w_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h22};
            c_op_ori: w_word = {6'h0D, in_rs, in_rt, in_imm};
            c_op_lw:  w_word = {6'h23, in_rs, in_rt, in_imm};
            c_op_sw:  w_word = {6'h2B, in_rs, in_rt, in_imm};
            c_op_beq: w_word = {6'h04, in_rs, in_rt, in_imm};
            c_op_lui: w_word = {6'h0F, 5'h00, in_rt, in_imm};
            c_op_jal: w_word = {6'h03, in_index};
            c_op_jr:  w_word = {6'h00, in_rs, 15'h0, 6'h08};
            default:  w_legal = 1'b0;
        endcase
    end

    // Full blocks acceptance outright, so a pop while full never admits a push.
    assign in_ready  = (r_level != c_full);
    assign out_valid = (r_level != '0);
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && w_legal;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_addr      <= BASE_ADDR;
            r_err       <= 1'b0;
            r_err_count <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_addr   <= r_addr + 32'd4;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            r_err <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    // Storage is not cleared by reset, so the head is masked while empty.
    assign out_word  = out_valid ? r_mem[r_rd_ptr] : 32'h0;
    assign out_addr  = r_addr;
    assign err       = r_err;
    assign err_count = r_err_count;
    assign level     = r_level;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Directed self-checking bench for instr_encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_index;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        err;
    logic [7:0]  err_count;
    logic [2:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_3000)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .in_index  (in_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .err       (err),
        .err_count (err_count),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] idx);
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm   = imm;
        in_index = idx;
    endtask

    // Directed encoding vectors: op, rs, rt, rd, imm, index, expected word.
    logic [3:0]  v_op  [9] = '{4'd3, 4'd7, 4'd6, 4'd5, 4'd8, 4'd9, 4'd0, 4'd2, 4'd4};
    logic [4:0]  v_rs  [9] = '{5'd0, 5'd7, 5'd1, 5'd0, 5'd3, 5'd31, 5'd9, 5'd1, 5'd29};
    logic [4:0]  v_rt  [9] = '{5'd5, 5'd1, 5'd2, 5'd2, 5'd4, 5'd6, 5'd9, 5'd2, 5'd8};
    logic [4:0]  v_rd  [9] = '{5'd9, 5'd3, 5'd7, 5'd1, 5'd5, 5'd2, 5'd9, 5'd3, 5'd4};
    logic [15:0] v_imm [9] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0004, 16'h5555,
                               16'hAAAA, 16'h7777, 16'h0000, 16'h0010};
    logic [25:0] v_idx [9] = '{26'h1, 26'h2, 26'h3, 26'h4, 26'hC00, 26'h5, 26'h6, 26'h7, 26'h8};
    logic [31:0] v_exp [9] = '{32'h3405_1234, 32'h3C01_FFFF, 32'h1022_FFFF, 32'hAC02_0004,
                               32'h0C00_0C00, 32'h03E0_0008, 32'h0000_0000, 32'h0022_1822,
                               32'h8FA8_0010};

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        req(4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        repeat (3) tick();

        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_word", out_word, 32'h0);
        check("rst_addr", out_addr, 32'h3000);
        check("rst_err", 32'(err), 32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        // First word latency and address
        out_ready = 1'b1;
        req(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_word", out_word, 32'h0022_1820);
        check("add_addr", out_addr, 32'h3000);
        tick();
        check("add_pop_valid", 32'(out_valid), 32'd0);
        check("add_pop_addr", out_addr, 32'h3004);

        // Encoding table
        for (int i = 0; i < 9; i++) begin
            req(v_op[i], v_rs[i], v_rt[i], v_rd[i], v_imm[i], v_idx[i]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check($sformatf("enc%0d_word", i), out_word, v_exp[i]);
            check($sformatf("enc%0d_addr", i), out_addr, 32'h3004 + 32'(4 * i));
            tick();
        end
        check("enc_empty", 32'(out_valid), 32'd0);

        // Fill under backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            req(4'd1, 5'd0, 5'd0, 5'(i), 16'h0, 26'h0);
            tick();
        end
        check("full_level", 32'(level), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        req(4'd1, 5'd0, 5'd0, 5'd5, 16'h0, 26'h0);
        tick();
        check("full_hold_level", 32'(level), 32'd4);
        check("full_hold_word", out_word, 32'h0000_0820);
        check("full_hold_addr", out_addr, 32'h3028);
        out_ready = 1'b1;
        tick();
        check("drain1_level", 32'(level), 32'd3);
        check("drain1_word", out_word, 32'h0000_1020);
        check("drain1_addr", out_addr, 32'h302C);
        tick();
        in_valid = 1'b0;
        check("drain2_level", 32'(level), 32'd3);
        check("drain2_word", out_word, 32'h0000_1820);
        check("drain2_addr", out_addr, 32'h3030);
        tick();
        check("drain3_word", out_word, 32'h0000_2020);
        check("drain3_addr", out_addr, 32'h3034);
        tick();
        check("drain4_word", out_word, 32'h0000_2820);
        check("drain4_level", 32'(level), 32'd1);
        tick();
        check("drain5_valid", 32'(out_valid), 32'd0);
        check("drain5_addr", out_addr, 32'h303C);

        // Illegal ops
        req(4'd12, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ill_err", 32'(err), 32'd1);
        check("ill_errcnt", 32'(err_count), 32'd1);
        check("ill_level", 32'(level), 32'd0);
        check("ill_valid", 32'(out_valid), 32'd0);
        tick();
        check("ill_err_drop", 32'(err), 32'd0);
        check("ill_errcnt_hold", 32'(err_count), 32'd1);
        req(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        in_valid = 1'b1;
        repeat (253) tick();
        check("ill_errcnt_254", 32'(err_count), 32'd254);
        repeat (47) tick();
        in_valid = 1'b0;
        check("ill_errcnt_sat", 32'(err_count), 32'hFF);
        check("ill_addr", out_addr, 32'h303C);
        tick();
        check("ill_errcnt_sat_hold", 32'(err_count), 32'hFF);

        // Simultaneous push/pop at level 2
        out_ready = 1'b0;
        in_valid  = 1'b1;
        req(4'd3, 5'd0, 5'd1, 5'd0, 16'h0001, 26'h0);
        tick();
        req(4'd3, 5'd0, 5'd1, 5'd0, 16'h0002, 26'h0);
        tick();
        check("pp_level_pre", 32'(level), 32'd2);
        out_ready = 1'b1;
        req(4'd3, 5'd0, 5'd1, 5'd0, 16'h0003, 26'h0);
        tick();
        check("pp1_level", 32'(level), 32'd2);
        check("pp1_word", out_word, 32'h3401_0002);
        req(4'd3, 5'd0, 5'd1, 5'd0, 16'h0004, 26'h0);
        tick();
        in_valid = 1'b0;
        check("pp2_level", 32'(level), 32'd2);
        check("pp2_word", out_word, 32'h3401_0003);
        tick();
        check("pp3_word", out_word, 32'h3401_0004);
        check("pp3_level", 32'(level), 32'd1);
        tick();
        check("pp_empty", 32'(level), 32'd0);
        check("pp_addr", out_addr, 32'h304C);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            req(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'(i));
            tick();
        end
        in_valid = 1'b0;
        check("mid_level", 32'(level), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_level", 32'(level), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_addr", out_addr, 32'h3000);
        check("arst_errcnt", 32'(err_count), 32'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        req(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h99);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_valid", 32'(out_valid), 32'd1);
        check("post_word", out_word, 32'h0C00_0099);
        check("post_addr", out_addr, 32'h3000);
        check("post_level", 32'(level), 32'd1);
        tick();
        check("post_pop_addr", out_addr, 32'h3004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
